// File: rtl/clock_pkg.sv
// Shared types, field widths and wrap helpers for the clock-setting controller.
package clock_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;

  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  // Encoding of the field output.
  localparam logic [1:0] FIELD_RUN = 2'b00;
  localparam logic [1:0] FIELD_HR  = 2'b01;
  localparam logic [1:0] FIELD_MIN = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  // Hour increment with compare-and-clear wrap 23 -> 0.
  function automatic logic [HR_W-1:0] hr_inc(input logic [HR_W-1:0] v);
    if (v >= HR_MAX) begin
      hr_inc = 5'd0;
    end else begin
      hr_inc = v + 5'd1;
    end
  endfunction

  // Minute increment with compare-and-clear wrap 59 -> 0.
  function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] v);
    if (v >= MIN_MAX) begin
      min_inc = 6'd0;
    end else begin
      min_inc = v + 6'd1;
    end
  endfunction

endpackage

// File: rtl/sec_strobe_gen.sv
// One-second prescaler. strobe and half are registered and line up with the
// count value held in the same cycle: strobe marks the last count of a
// second, half marks the first half of the second.
module sec_strobe_gen #(
  parameter int CLK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic strobe,
  output logic half
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALFV = CW'(CLK_DIV / 2);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Next prescaler value: restart has priority over the normal wrap.
  always_comb begin
    count_next = {CW{1'b0}};
    if (restart) begin
      count_next = {CW{1'b0}};
    end else if (count == LAST) begin
      count_next = {CW{1'b0}};
    end else begin
      count_next = count + CW'(1);
    end
  end

  // Prescaler register and its registered decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= {CW{1'b0}};
      strobe <= 1'b0;
      half   <= 1'b1;
    end else begin
      count  <= count_next;
      strobe <= (count_next == LAST);
      half   <= (count_next < HALFV);
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller: runs the time-counter tick, lets the user edit
// hours then minutes with two buttons, and commits with a one-cycle load.
// An idle session times out back to RUN without loading.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_DIV   = 100_000_000,
  parameter int TIMEOUT_S = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  output logic             tick,
  output logic             load,
  output logic [HR_W-1:0]  load_hr,
  output logic [MIN_W-1:0] load_min,
  output logic             setting,
  output logic [1:0]       field,
  output logic             blink
);

  localparam int TW = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_S - 1);

  state_t           state;
  logic [TW-1:0]    tcnt;
  logic [HR_W-1:0]  edit_hr;
  logic [MIN_W-1:0] edit_min;
  logic             mode_prev;
  logic             inc_prev;
  logic             mode_edge;
  logic             inc_edge;
  logic             restart;
  logic             strobe;
  logic             half;

  assign mode_edge = btn_mode & ~mode_prev;
  assign inc_edge  = btn_inc  & ~inc_prev;

  // Restarting on the commit edge puts count 0 in the load cycle, so the
  // first tick after load lands a full second later.
  assign restart = (state == ST_SET_MIN) & mode_edge;

  sec_strobe_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sec (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .strobe  (strobe),
    .half    (half)
  );

  assign load_hr  = edit_hr;
  assign load_min = edit_min;
  assign blink    = setting & half;

  // Session FSM with edge detection, timeout counting and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      tcnt      <= {TW{1'b0}};
      edit_hr   <= 5'd0;
      edit_min  <= 6'd0;
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
      tick      <= 1'b0;
      load      <= 1'b0;
      setting   <= 1'b0;
      field     <= FIELD_RUN;
    end else begin
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
      tick      <= strobe & (state == ST_RUN);
      load      <= 1'b0;
      case (state)
        ST_RUN: begin
          if (mode_edge) begin
            state    <= ST_SET_HR;
            edit_hr  <= cur_hr;
            edit_min <= cur_min;
            tcnt     <= {TW{1'b0}};
            setting  <= 1'b1;
            field    <= FIELD_HR;
          end
        end
        ST_SET_HR: begin
          if (mode_edge) begin
            state <= ST_SET_MIN;
            tcnt  <= {TW{1'b0}};
            field <= FIELD_MIN;
          end else if (inc_edge) begin
            edit_hr <= hr_inc(edit_hr);
            tcnt    <= {TW{1'b0}};
          end else if (strobe) begin
            if (tcnt >= TIMEOUT_LAST) begin
              state   <= ST_RUN;
              tcnt    <= {TW{1'b0}};
              setting <= 1'b0;
              field   <= FIELD_RUN;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        ST_SET_MIN: begin
          if (mode_edge) begin
            state   <= ST_COMMIT;
            tcnt    <= {TW{1'b0}};
            load    <= 1'b1;
            setting <= 1'b0;
            field   <= FIELD_RUN;
          end else if (inc_edge) begin
            edit_min <= min_inc(edit_min);
            tcnt     <= {TW{1'b0}};
          end else if (strobe) begin
            if (tcnt >= TIMEOUT_LAST) begin
              state   <= ST_RUN;
              tcnt    <= {TW{1'b0}};
              setting <= 1'b0;
              field   <= FIELD_RUN;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        ST_COMMIT: begin
          state <= ST_RUN;
        end
        default: begin
          state   <= ST_RUN;
          tcnt    <= {TW{1'b0}};
          setting <= 1'b0;
          field   <= FIELD_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with CLK_DIV=10, TIMEOUT_S=3: directed scenarios
// with literal expectations, then randomized buttons checked each cycle
// against a behavioural model of the setting session.
module tb_clock_set_ctrl;

  localparam int CLK_DIV   = 10;
  localparam int TIMEOUT_S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hr = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic       tick, load, setting, blink;
  logic [4:0] load_hr;
  logic [5:0] load_min;
  logic [1:0] field;

  clock_set_ctrl #(.CLK_DIV(CLK_DIV), .TIMEOUT_S(TIMEOUT_S)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hr(cur_hr), .cur_min(cur_min), .tick(tick), .load(load),
    .load_hr(load_hr), .load_min(load_min), .setting(setting),
    .field(field), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;
  bit done     = 1'b0;

  // Model: sess 0 = running, 1 = editing hours, 2 = editing minutes,
  // 3 = the commit cycle. phase = position within the current second.
  int m_phase = 0, m_sess = 0, m_hr = 0, m_min = 0, m_idle = 0;
  bit m_pm = 1'b1, m_pi = 1'b1, e_tick = 1'b0, e_load = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic model_step();
    bit sec_done, me, ie;
    if (rst) begin
      m_phase = 0; m_sess = 0; m_hr = 0; m_min = 0; m_idle = 0;
      m_pm = 1'b1; m_pi = 1'b1; e_tick = 1'b0; e_load = 1'b0;
    end else begin
      sec_done = (m_phase == CLK_DIV - 1);
      me = btn_mode && !m_pm;
      ie = btn_inc && !m_pi;
      e_tick = sec_done && (m_sess == 0);
      e_load = 1'b0;
      m_phase = (m_phase + 1) % CLK_DIV;
      case (m_sess)
        0: if (me) begin
             m_sess = 1; m_hr = int'(cur_hr); m_min = int'(cur_min); m_idle = 0;
           end
        1, 2: begin
          if (me) begin
            m_idle = 0;
            if (m_sess == 1) m_sess = 2;
            else begin m_sess = 3; e_load = 1'b1; m_phase = 0; end
          end else if (ie) begin
            m_idle = 0;
            if (m_sess == 1) m_hr = (m_hr + 1) % 24;
            else m_min = (m_min + 1) % 60;
          end else if (sec_done) begin
            m_idle++;
            if (m_idle >= TIMEOUT_S) begin m_sess = 0; m_idle = 0; end
          end
        end
        default: m_sess = 0;
      endcase
      m_pm = btn_mode;
      m_pi = btn_inc;
    end
    started = 1'b1;
  endtask

  function automatic int expected_vec();
    bit s;
    int f;
    s = (m_sess == 1) || (m_sess == 2);
    f = (m_sess == 1) ? 1 : ((m_sess == 2) ? 2 : 0);
    return (int'(e_tick) << 16) | (int'(e_load) << 15) | (int'(s) << 14) |
           (f << 12) | (int'(s && (m_phase < CLK_DIV / 2)) << 11) |
           (m_hr << 6) | m_min;
  endfunction

  function automatic int actual_vec();
    return int'({15'd0, tick, load, setting, field, blink, load_hr, load_min});
  endfunction

  // Every edge passes through here so the model sees each sampled input set.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #2;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc(1);
    btn_mode = 1'b0; cyc(1);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; cyc(1);
    btn_inc = 1'b0; cyc(1);
  endtask

  // Per-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (started && !done) check("cycle_outputs", actual_vec(), expected_vec());
    end
  end

  initial begin
    int ticks[$];
    int loads, k_load, k_tick, n;
    bit seen_load;

    // Reset state
    cyc(3);
    check("reset_outputs", actual_vec(), 0);

    // Idle run after reset: ticks 10, 20, 30 edges after release
    rst = 1'b0;
    loads = 0;
    for (int k = 1; k <= 35; k++) begin
      cyc(1);
      if (tick) ticks.push_back(k);
      if (load) loads++;
    end
    check("idle_tick_count", ticks.size(), 3);
    if (ticks.size() == 3) begin
      check("idle_tick0", ticks[0], 10);
      check("idle_tick1", ticks[1], 20);
      check("idle_tick2", ticks[2], 30);
    end
    check("idle_no_load", loads, 0);

    // Full edit from 23:59 with wraps, commit and tick realignment
    cur_hr = 5'd23; cur_min = 6'd59;
    press_mode();
    check("enter_field_hr", int'(field), 1);
    check("enter_capture_hr", int'(load_hr), 23);
    press_inc();
    press_mode();
    press_inc();
    press_inc();
    btn_mode = 1'b1;
    loads = 0; k_load = -1; k_tick = -1;
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      btn_mode = 1'b0;
      if (load) begin
        loads++;
        if (k_load < 0) begin
          k_load = k;
          check("commit_load_hr", int'(load_hr), 0);
          check("commit_load_min", int'(load_min), 1);
        end
      end
      if (tick && k_load >= 0 && k_tick < 0) k_tick = k;
    end
    check("commit_load_count", loads, 1);
    check("commit_tick_delay", k_tick - k_load, 10);

    // Idle session times out after three strobes with no load
    cur_hr = 5'd7; cur_min = 6'd30;
    btn_mode = 1'b1; cyc(1);
    check("timeout_enter", int'(setting), 1);
    btn_mode = 1'b0;
    n = 0; seen_load = 1'b0;
    while (setting && n < 40) begin
      cyc(1); n++;
      if (load) seen_load = 1'b1;
    end
    check("timeout_window", int'(n >= 21 && n <= 30), 1);
    check("timeout_no_load", int'(seen_load), 0);
    n = 0;
    while (!tick && n < 20) begin cyc(1); n++; end
    check("timeout_tick_resume", n, 10);

    // Mode and inc together in SET_HR: mode wins
    cur_hr = 5'd5; cur_min = 6'd12;
    press_mode();
    btn_mode = 1'b1; btn_inc = 1'b1; cyc(1);
    check("simul_field", int'(field), 2);
    check("simul_edit_hr", int'(load_hr), 5);
    btn_mode = 1'b0; btn_inc = 1'b0; cyc(1);

    // Reset mid-session with inc pressed: no load, outputs at reset values
    btn_inc = 1'b1; rst = 1'b1; cyc(1);
    check("midrst_outputs", actual_vec(), 0);
    rst = 1'b0; btn_inc = 1'b0; cyc(1);
    check("midrst_after", actual_vec(), 0);

    // Mode held through reset release produces no edge
    rst = 1'b1; btn_mode = 1'b1; cyc(2);
    rst = 1'b0; cyc(5);
    check("held_no_session", int'(setting), 0);
    btn_mode = 1'b0; cyc(1);
    press_mode();
    check("held_repress", int'(setting), 1);
    cyc(40);

    // Randomized buttons, live time values and occasional resets
    for (int seg = 0; seg < 15; seg++) begin
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, (seg % 3 == 0) ? 7 : 23) == 0) btn_mode = !btn_mode;
        if ($urandom_range(0, (seg % 3 == 2) ? 63 : 3) == 0) btn_inc = !btn_inc;
        if ($urandom_range(0, 15) == 0) begin
          cur_hr  = 5'($urandom_range(0, 23));
          cur_min = 6'($urandom_range(0, 59));
        end
        rst = ($urandom_range(0, 499) == 0);
        cyc(1);
      end
    end
    rst = 1'b0;
    cyc(2);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
